// File: rtl/adpcm_rom_sequencer.sv
// ADPCM sample playback sequencer: fetches packed bytes from ROM and feeds nibbles to the decoder.
// Optional looping playback is enabled by defining ADPCM_SEQ_LOOP_EN.
module adpcm_rom_sequencer #(
  parameter int AW       = 16,
  parameter bit HI_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen_lo,
  input  logic          cpu_wr,
  input  logic [2:0]    cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic [7:0]    cpu_dout,
  output logic          rom_cs,
  output logic [AW-1:0] rom_addr,
  input  logic [7:0]    rom_data,
  input  logic          rom_ok,
  output logic [3:0]    adpcm_din,
  output logic          adpcm_rst,
  output logic          irq
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRIME = 2'd1;
  localparam logic [1:0] ST_PLAY  = 2'd2;

  logic [1:0]    state;
  logic [15:0]   start_r, end_r;
  logic [AW-1:0] cur, end_act;
  logic          end_hit;
  logic [7:0]    shift_r, pre_r;
  logic          shift_valid, shift_is_end, ptr;
  logic          pre_valid, pre_is_end;
  logic          done_pending, underrun, irq_r;
  logic          loop_on;

  logic          ctrl_wr, play_on, play_off, flag_clr, busy, at_end;
  logic [AW-1:0] adv_cur, adv_end_act;
  logic          adv_end_hit;

`ifdef ADPCM_SEQ_LOOP_EN
  logic loop_r, irq_pulse;
  assign loop_on = loop_r;
  assign irq     = irq_r | irq_pulse;
`else
  assign loop_on = 1'b0;
  assign irq     = irq_r;
`endif

  assign ctrl_wr  = cpu_wr && (cpu_addr == 3'd4);
  assign play_on  = ctrl_wr && cpu_din[0];
  assign play_off = ctrl_wr && !cpu_din[0];
  assign flag_clr = ctrl_wr && cpu_din[7];
  assign busy     = (state != ST_IDLE);
  assign cpu_dout = {busy, underrun, irq, 5'd0};

  // ROM handshake: rom_cs is a level request holding rom_addr stable; a byte is
  // accepted on the clk where rom_cs && rom_ok, and the request drops that same edge
  // whenever no further byte is wanted. rom_ok without rom_cs is ignored.
  assign rom_cs   = (state == ST_PRIME) || ((state == ST_PLAY) && !pre_valid && !end_hit);
  assign rom_addr = cur;
  assign at_end   = (cur == end_act);

  // Address step after an accepted byte: wrap at end (loop) or park on end.
  always_comb begin
    adv_cur     = cur + {{(AW-1){1'b0}}, 1'b1};
    adv_end_act = end_act;
    adv_end_hit = 1'b0;
    if (at_end) begin
      if (loop_on) begin
        adv_cur     = start_r[AW-1:0];
        adv_end_act = end_r[AW-1:0];
      end else begin
        adv_cur     = cur;
        adv_end_hit = 1'b1;
      end
    end
  end

  function automatic logic [3:0] nib(input logic [7:0] b, input logic second);
    return (HI_FIRST ^ second) ? b[7:4] : b[3:0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      start_r      <= '0;
      end_r        <= '0;
      cur          <= '0;
      end_act      <= '0;
      end_hit      <= 1'b0;
      shift_r      <= '0;
      shift_valid  <= 1'b0;
      shift_is_end <= 1'b0;
      ptr          <= 1'b0;
      pre_r        <= '0;
      pre_valid    <= 1'b0;
      pre_is_end   <= 1'b0;
      done_pending <= 1'b0;
      underrun     <= 1'b0;
      irq_r        <= 1'b0;
      adpcm_din    <= '0;
      adpcm_rst    <= 1'b1;
`ifdef ADPCM_SEQ_LOOP_EN
      loop_r       <= 1'b0;
      irq_pulse    <= 1'b0;
`endif
    end else begin
      if (cpu_wr) begin
        case (cpu_addr)
          3'd0:    start_r[7:0]  <= cpu_din;
          3'd1:    start_r[15:8] <= cpu_din;
          3'd2:    end_r[7:0]    <= cpu_din;
          3'd3:    end_r[15:8]   <= cpu_din;
          default: ;
        endcase
      end
`ifdef ADPCM_SEQ_LOOP_EN
      irq_pulse <= 1'b0;
      if (ctrl_wr) loop_r <= cpu_din[1];
`endif
      if (flag_clr) begin
        irq_r    <= 1'b0;
        underrun <= 1'b0;
      end

      if (play_on) begin
        state        <= ST_PRIME;
        cur          <= start_r[AW-1:0];
        end_act      <= end_r[AW-1:0];
        end_hit      <= 1'b0;
        shift_valid  <= 1'b0;
        pre_valid    <= 1'b0;
        ptr          <= 1'b0;
        done_pending <= 1'b0;
        adpcm_rst    <= 1'b1;
        adpcm_din    <= '0;
      end else if (play_off) begin
        state        <= ST_IDLE;
        adpcm_rst    <= 1'b1;
        done_pending <= 1'b0;
      end else begin
        case (state)
          ST_PRIME: begin
            if (rom_ok) begin
              shift_r      <= rom_data;
              shift_valid  <= 1'b1;
              shift_is_end <= at_end;
              cur          <= adv_cur;
              end_act      <= adv_end_act;
              end_hit      <= adv_end_hit;
              state        <= ST_PLAY;
              adpcm_rst    <= 1'b0;
            end
          end
          ST_PLAY: begin
            if (rom_cs && rom_ok) begin
              pre_r      <= rom_data;
              pre_valid  <= 1'b1;
              pre_is_end <= at_end;
              cur        <= adv_cur;
              end_act    <= adv_end_act;
              end_hit    <= adv_end_hit;
            end
            if (cen_lo) begin
              if (done_pending) begin
                state        <= ST_IDLE;
                adpcm_rst    <= 1'b1;
                adpcm_din    <= '0;
                done_pending <= 1'b0;
              end else if (!ptr) begin
                if (shift_valid) begin
                  adpcm_din <= nib(shift_r, 1'b0);
                  ptr       <= 1'b1;
                end else if (pre_valid) begin
                  // Late byte finally arrived: start it straight from pre.
                  adpcm_din    <= nib(pre_r, 1'b0);
                  shift_r      <= pre_r;
                  shift_is_end <= pre_is_end;
                  shift_valid  <= 1'b1;
                  pre_valid    <= 1'b0;
                  ptr          <= 1'b1;
                end else begin
                  adpcm_din <= '0;
                  underrun  <= 1'b1;
                end
              end else begin
                adpcm_din <= nib(shift_r, 1'b1);
                ptr       <= 1'b0;
                if (shift_is_end && !loop_on) begin
                  done_pending <= 1'b1;
                end else begin
`ifdef ADPCM_SEQ_LOOP_EN
                  if (shift_is_end) irq_pulse <= 1'b1;
`endif
                  if (pre_valid) begin
                    shift_r      <= pre_r;
                    shift_is_end <= pre_is_end;
                    pre_valid    <= 1'b0;
                  end else begin
                    shift_valid <= 1'b0;
                  end
                end
              end
            end
          end
          default: ;
        endcase
      end

      // End-of-sample set takes priority over a same-cycle clear.
      if ((state == ST_PLAY) && cen_lo && done_pending) irq_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adpcm_rom_sequencer.sv
// Directed bench for adpcm_rom_sequencer: ROM responder, strobe generator, nibble/address logs.
module tb_adpcm_rom_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cen_lo = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [2:0]  cpu_addr = '0;
  logic [7:0]  cpu_din = '0;
  logic [7:0]  cpu_dout;
  logic        rom_cs;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data = '0;
  logic        rom_ok = 1'b0;
  logic [3:0]  adpcm_din;
  logic        adpcm_rst;
  logic        irq;

  adpcm_rom_sequencer #(.AW(16), .HI_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .cen_lo(cen_lo), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .rom_cs(rom_cs), .rom_addr(rom_addr),
    .rom_data(rom_data), .rom_ok(rom_ok), .adpcm_din(adpcm_din), .adpcm_rst(adpcm_rst),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0]  rom_mem [0:65535];
  logic [3:0]  got_q[$];
  logic [15:0] addr_q[$];
  int          rom_lat = 1;
  int          rom_cnt = 0;
  bit          rom_auto = 1'b1;
  bit          force_ok = 1'b0;
  logic [7:0]  force_data = '0;
  bit          cen_auto = 1'b1;
  bit          cen_req = 1'b0;
  int          cen_period = 4;
  int          cen_cnt = 0;
  bit          pend = 1'b0;
  int          irq_cnt = 0;

  // Environment on the falling edge: log issued nibbles, answer ROM requests, drive cen_lo.
  always @(negedge clk) begin
    if (pend && !adpcm_rst) got_q.push_back(adpcm_din);
    if (irq) irq_cnt = irq_cnt + 1;
    if (rom_auto) begin
      if (rom_ok) begin
        rom_ok = 1'b0;
        rom_cnt = 0;
      end else if (rom_cs) begin
        rom_cnt = rom_cnt + 1;
        if (rom_cnt >= rom_lat) begin
          rom_ok = 1'b1;
          rom_data = rom_mem[rom_addr];
          addr_q.push_back(rom_addr);
          rom_cnt = 0;
        end
      end else begin
        rom_cnt = 0;
      end
    end else begin
      rom_ok = force_ok;
      rom_data = force_data;
      rom_cnt = 0;
    end
    if (cen_auto) begin
      cen_lo = (cen_cnt == 0);
      cen_cnt = (cen_cnt + 1 >= cen_period) ? 0 : cen_cnt + 1;
    end else begin
      cen_lo = cen_req;
    end
    pend = cen_lo && cpu_dout[7] && !adpcm_rst;
  end

  function automatic logic [31:0] pack_nibs(input bit skip_zero);
    logic [31:0] v;
    int n;
    v = '0;
    n = 0;
    foreach (got_q[i]) begin
      if (!(skip_zero && got_q[i] == 4'h0) && n < 8) begin
        v = {v[27:0], got_q[i]};
        n++;
      end
    end
    return v;
  endfunction

  function automatic int zero_count();
    int n;
    n = 0;
    foreach (got_q[i]) if (got_q[i] == 4'h0) n++;
    return n;
  endfunction

  function automatic logic [47:0] pack_addrs();
    logic [47:0] v;
    v = '0;
    foreach (addr_q[i]) if (i < 3) v = {v[31:0], addr_q[i]};
    return v;
  endfunction

  task automatic cpu_write(input logic [2:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    cpu_wr = 1'b1; cpu_addr = a; cpu_din = d;
    @(posedge clk); #1;
    cpu_wr = 1'b0;
  endtask

  task automatic set_window(input logic [15:0] s, input logic [15:0] e);
    cpu_write(3'd0, s[7:0]);
    cpu_write(3'd1, s[15:8]);
    cpu_write(3'd2, e[7:0]);
    cpu_write(3'd3, e[15:8]);
  endtask

  task automatic wait_idle(input int limit, input string name);
    int i;
    for (i = 0; i < limit; i++) begin
      @(posedge clk); #1;
      if (!cpu_dout[7]) break;
    end
    if (cpu_dout[7]) begin
      tests++; fails++;
      $display("FAIL %s timeout: busy still %0b after %0d clk, required 0", name, cpu_dout[7], limit);
    end
  endtask

  task automatic wait_play(input int limit, input string name);
    int i;
    for (i = 0; i < limit; i++) begin
      @(posedge clk); #1;
      if (!adpcm_rst) break;
    end
    if (adpcm_rst) begin
      tests++; fails++;
      $display("FAIL %s timeout: adpcm_rst still 1 after %0d clk, required 0", name, limit);
    end
  endtask

  task automatic cen_pulse();
    @(posedge clk); #1 cen_req = 1'b1;
    @(posedge clk); #1 cen_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (rom_cs !== 1'b0) begin fails++; $display("FAIL reset_rom_cs got %b exp 0", rom_cs); end
    tests++; if (rom_addr !== 16'h0) begin fails++; $display("FAIL reset_rom_addr got %h exp 0000", rom_addr); end
    tests++; if (adpcm_din !== 4'h0) begin fails++; $display("FAIL reset_adpcm_din got %h exp 0", adpcm_din); end
    tests++; if (adpcm_rst !== 1'b1) begin fails++; $display("FAIL reset_adpcm_rst got %b exp 1", adpcm_rst); end
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq got %b exp 0", irq); end
    tests++; if (cpu_dout !== 8'h00) begin fails++; $display("FAIL reset_cpu_dout got %h exp 00", cpu_dout); end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_basic_play();
    rom_mem[16'h0010] = 8'h12; rom_mem[16'h0011] = 8'h34; rom_mem[16'h0012] = 8'h56;
    rom_lat = 1; cen_auto = 1'b1; cen_period = 4;
    set_window(16'h0010, 16'h0012);
    got_q.delete(); addr_q.delete();
    cpu_write(3'd4, 8'h01);
    tests++; if (cpu_dout[7] !== 1'b1) begin fails++; $display("FAIL basic_busy got %b exp 1", cpu_dout[7]); end
    wait_idle(500, "basic");
    repeat (4) @(posedge clk); #1;
    tests++; if (got_q.size() != 6 || pack_nibs(1'b0) !== 32'h00123456) begin
      fails++; $display("FAIL basic_nibbles got %0d:%h exp 6:00123456", got_q.size(), pack_nibs(1'b0)); end
    tests++; if (addr_q.size() != 3 || pack_addrs() !== 48'h001000110012) begin
      fails++; $display("FAIL basic_addrs got %0d:%h exp 3:001000110012", addr_q.size(), pack_addrs()); end
    tests++; if (adpcm_rst !== 1'b1) begin fails++; $display("FAIL basic_adpcm_rst got %b exp 1", adpcm_rst); end
    tests++; if (irq !== 1'b1 || cpu_dout !== 8'h20) begin
      fails++; $display("FAIL basic_status got irq=%b dout=%h exp irq=1 dout=20", irq, cpu_dout); end
    cpu_write(3'd4, 8'h80);
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL basic_irq_clear got %b exp 0", irq); end
  endtask

  task automatic test_wrap();
    rom_mem[16'hFFFF] = 8'h78; rom_mem[16'h0000] = 8'h9B; rom_mem[16'h0001] = 8'hCD;
    set_window(16'hFFFF, 16'h0001);
    got_q.delete(); addr_q.delete();
    cpu_write(3'd4, 8'h01);
    wait_idle(500, "wrap");
    repeat (4) @(posedge clk); #1;
    tests++; if (addr_q.size() != 3 || pack_addrs() !== 48'hFFFF00000001) begin
      fails++; $display("FAIL wrap_addrs got %0d:%h exp 3:FFFF00000001", addr_q.size(), pack_addrs()); end
    tests++; if (got_q.size() != 6 || pack_nibs(1'b0) !== 32'h00789BCD) begin
      fails++; $display("FAIL wrap_nibbles got %0d:%h exp 6:00789BCD", got_q.size(), pack_nibs(1'b0)); end
    tests++; if (irq !== 1'b1) begin fails++; $display("FAIL wrap_irq got %b exp 1", irq); end
    cpu_write(3'd4, 8'h80);
  endtask

  task automatic test_underrun();
    rom_mem[16'h0030] = 8'h9A; rom_mem[16'h0031] = 8'hBC;
    rom_lat = 40; cen_period = 8;
    set_window(16'h0030, 16'h0031);
    got_q.delete();
    cpu_write(3'd4, 8'h01);
    wait_idle(3000, "underrun");
    #1;
    tests++; if (cpu_dout[6] !== 1'b1) begin fails++; $display("FAIL underrun_flag got %b exp 1", cpu_dout[6]); end
    tests++; if (zero_count() < 1) begin fails++; $display("FAIL underrun_zero_nibble got %0d zeros exp >=1", zero_count()); end
    tests++; if (pack_nibs(1'b1) !== 32'h00009ABC) begin
      fails++; $display("FAIL underrun_order got %h exp 00009ABC", pack_nibs(1'b1)); end
    cpu_write(3'd4, 8'h80);
    tests++; if (cpu_dout !== 8'h00) begin fails++; $display("FAIL underrun_clear got %h exp 00", cpu_dout); end
    rom_lat = 1; cen_period = 4;
  endtask

  task automatic test_stop();
    rom_auto = 1'b0; force_ok = 1'b0;
    set_window(16'h0040, 16'h0045);
    got_q.delete();
    cpu_write(3'd4, 8'h01);
    repeat (2) @(posedge clk); #1;
    tests++; if (rom_cs !== 1'b1 || rom_addr !== 16'h0040) begin
      fails++; $display("FAIL stop_request got cs=%b addr=%h exp cs=1 addr=0040", rom_cs, rom_addr); end
    cpu_write(3'd4, 8'h00);
    force_ok = 1'b1; force_data = 8'hFF;
    @(posedge clk); #1 force_ok = 1'b0;
    repeat (2) @(posedge clk); #1;
    tests++; if (rom_cs !== 1'b0 || cpu_dout[7] !== 1'b0) begin
      fails++; $display("FAIL stop_idle got cs=%b busy=%b exp 0 0", rom_cs, cpu_dout[7]); end
    tests++; if (rom_addr !== 16'h0040) begin fails++; $display("FAIL stop_ignore_ok got addr=%h exp 0040", rom_addr); end
    tests++; if (irq !== 1'b0 || adpcm_rst !== 1'b1 || got_q.size() != 0) begin
      fails++; $display("FAIL stop_quiet got irq=%b rst=%b nibs=%0d exp 0 1 0", irq, adpcm_rst, got_q.size()); end
    rom_auto = 1'b1;
  endtask

  task automatic test_retrigger();
    rom_mem[16'h0060] = 8'h3C; rom_mem[16'h0061] = 8'h5D; rom_mem[16'h0070] = 8'hE7;
    cen_auto = 1'b0; cen_req = 1'b0;
    set_window(16'h0060, 16'h0061);
    got_q.delete();
    cpu_write(3'd4, 8'h01);
    wait_play(50, "retrig_prime1");
    cen_pulse();
    set_window(16'h0070, 16'h0070);
    cpu_write(3'd4, 8'h01);
    wait_play(50, "retrig_prime2");
    repeat (3) cen_pulse();
    tests++; if (got_q.size() != 3 || pack_nibs(1'b0) !== 32'h000003E7) begin
      fails++; $display("FAIL retrig_nibbles got %0d:%h exp 3:000003E7", got_q.size(), pack_nibs(1'b0)); end
    tests++; if (cpu_dout !== 8'h20) begin fails++; $display("FAIL retrig_status got %h exp 20", cpu_dout); end
    cpu_write(3'd4, 8'h80);
  endtask

  task automatic test_irq_race();
    rom_mem[16'h0050] = 8'h12;
    set_window(16'h0050, 16'h0050);
    got_q.delete();
    cpu_write(3'd4, 8'h01);
    wait_play(50, "race_prime");
    repeat (2) cen_pulse();
    @(posedge clk); #1;
    cen_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 3'd4; cpu_din = 8'h80;
    @(posedge clk); #1;
    cen_req = 1'b0; cpu_wr = 1'b0;
    @(posedge clk); #1;
    tests++; if (irq !== 1'b1 || cpu_dout !== 8'h20) begin
      fails++; $display("FAIL race_irq got irq=%b dout=%h exp 1 20", irq, cpu_dout); end
    tests++; if (pack_nibs(1'b0) !== 32'h00000012) begin
      fails++; $display("FAIL race_nibbles got %h exp 00000012", pack_nibs(1'b0)); end
    cpu_write(3'd4, 8'h80);
    cen_auto = 1'b1;
  endtask

  task automatic test_async_reset();
    rom_auto = 1'b0; force_ok = 1'b0;
    set_window(16'h1234, 16'h1240);
    cpu_write(3'd4, 8'h01);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    tests++; if (rom_cs !== 1'b0 || rom_addr !== 16'h0 || adpcm_rst !== 1'b1 || cpu_dout !== 8'h00) begin
      fails++; $display("FAIL async_reset got cs=%b addr=%h rst=%b dout=%h exp 0 0000 1 00",
                        rom_cs, rom_addr, adpcm_rst, cpu_dout); end
    @(negedge clk) rst = 1'b0;
    rom_auto = 1'b1;
  endtask

`ifdef ADPCM_SEQ_LOOP_EN
  task automatic test_loop();
    int i;
    int pulses;
    rom_mem[16'h0020] = 8'hA5;
    rom_lat = 1; cen_auto = 1'b1; cen_period = 4;
    set_window(16'h0020, 16'h0020);
    got_q.delete();
    irq_cnt = 0;
    cpu_write(3'd4, 8'h03);
    for (i = 0; i < 500; i++) begin
      @(posedge clk);
      if (got_q.size() >= 8) break;
    end
    pulses = irq_cnt;
    cpu_write(3'd4, 8'h00);
    tests++; if (got_q.size() < 8 || pack_nibs(1'b0) !== 32'hA5A5A5A5) begin
      fails++; $display("FAIL loop_nibbles got %0d:%h exp 8:A5A5A5A5", got_q.size(), pack_nibs(1'b0)); end
    tests++; if (pulses != 4) begin fails++; $display("FAIL loop_irq_pulses got %0d exp 4", pulses); end
    wait_idle(20, "loop_stop");
  endtask
`endif

  initial begin
    foreach (rom_mem[i]) rom_mem[i] = 8'h00;
    test_reset();
    test_basic_play();
    test_wrap();
    test_underrun();
    test_stop();
    test_retrigger();
    test_irq_race();
    test_async_reset();
`ifdef ADPCM_SEQ_LOOP_EN
    test_loop();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
